// File: rtl/dde_pkg.sv
// Shared types and helpers for the dual-edge deserializer.
package dde_pkg;

  // Word-assembly FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    ASM  = 1'b1
  } state_t;

  // Default word width and the matching number of bit pairs per word.
  localparam int WORD_W_DEF = 8;
  localparam int PAIRS      = WORD_W_DEF / 2;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Pair-counter width; never narrower than one bit.
  function automatic int cnt_w(input int pairs);
    return (clog2(pairs) < 1) ? 1 : clog2(pairs);
  endfunction

endpackage

// File: rtl/dde_deser_if.sv
// Output word stream of the deserializer.
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and out_data
// stays stable while out_valid=1 and the word has not transferred.
interface dde_deser_if #(
  parameter int WORD_W = 8
) ();
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/dde_fifo.sv
// Small first-word-fall-through FIFO with a registered head word.
module dde_fifo
  import dde_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int AW = clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic              pop_ok;
  logic              push_ok;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop on the same edge frees a slot, so a push into a full FIFO succeeds.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next pointers and next head word; a word written this edge that becomes
  // the head is forwarded directly since the array is not updated yet.
  always_comb begin
    wr_d   = wr_q + (AW+1)'(push_ok);
    rd_d   = rd_q + (AW+1)'(pop_ok);
    head_d = mem_q[rd_d[AW-1:0]];
    if (wr_d == rd_d) begin
      head_d = '0;
    end else if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      head_d = push_data_i;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  // Pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  assign head_o = head_q;

endmodule

// File: rtl/dde_deser.sv
// Dual-edge deserializer: captures one bit per clk edge, assembles framed
// words on posedge and queues them for a valid/ready consumer.
module dde_deser
  import dde_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        din_en,
  input  logic        sof,
  input  logic        clr_err,
  output logic        ovf,
  output logic        frm_err,
  output state_t      dbg_state,
  dde_deser_if.master out_if
);

  localparam int NP = WORD_W / 2;
  localparam int CW = cnt_w(NP);
  localparam logic [CW-1:0] LAST = CW'(NP - 1);

  logic              p_bit_q, n_bit_q, en_q, sof_q;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              push;
  logic              frm_set;
  logic              ovf_set;
  logic              fifo_empty, fifo_full;
  logic [WORD_W-1:0] fifo_head;
  logic [1:0]        pair;

  // Rising-edge capture: first bit of the pair plus its qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_bit_q <= 1'b0;
      en_q    <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      p_bit_q <= din;
      en_q    <= din_en;
      sof_q   <= sof & din_en;
    end
  end

  // Falling-edge capture: second bit of the pair.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) n_bit_q <= 1'b0;
    else        n_bit_q <= din;
  end

  // The earlier (rising-edge) bit lands in the lower position.
  assign pair = {n_bit_q, p_bit_q};

  // Word assembly: next state, pair slot, word completion and framing error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    frm_set = 1'b0;
    if (en_q) begin
      case (state_q)
        IDLE: begin
          if (sof_q) begin
            shreg_d      = '0;
            shreg_d[1:0] = pair;
            cnt_d        = CW'(1);
            state_d      = ASM;
          end
        end
        ASM: begin
          if (sof_q) begin
            if (cnt_q != '0) frm_set = 1'b1;
            shreg_d      = '0;
            shreg_d[1:0] = pair;
            cnt_d        = CW'(1);
          end else begin
            // A fresh word starts from a clean register.
            if (cnt_q == '0) shreg_d = '0;
            shreg_d[{cnt_q, 1'b0} +: 2] = pair;
            if (cnt_q == LAST) begin
              push  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, pair counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // A completed word is lost only if the FIFO is full and not popping.
  assign ovf_set = push && fifo_full && !(out_if.out_ready && !fifo_empty);

  // Sticky error flags; a set event wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (frm_set)      frm_err <= 1'b1;
      else if (clr_err) frm_err <= 1'b0;
    end
  end

  dde_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (shreg_d),
    .pop_i       (out_if.out_ready),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_head;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dde_deser.sv
// Bench for dde_deser: table of single-word vectors, hand sequences for
// framing/overflow/reset, and a randomized run against a bit-list model.
module tb_dde_deser;
  import dde_pkg::*;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int NP = W / 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n, din, din_en, sof, clr_err, ovf, frm_err;
  state_t dbg_state;

  dde_deser_if #(.WORD_W(W)) ifc ();

  dde_deser #(.WORD_W(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_en    (din_en),
    .sof       (sof),
    .clr_err   (clr_err),
    .ovf       (ovf),
    .frm_err   (frm_err),
    .dbg_state (dbg_state),
    .out_if    (ifc)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];      // words the model says sit in the FIFO
  logic [W-1:0] got_q[$];      // words actually handed over
  int           valid_edges[$];
  bit           m_bits[$];     // bits of the word being assembled
  bit           m_in_frame;
  bit           exp_ovf, exp_frm;
  bit           pd_en, pd_sof, pd_b0, pd_b1;
  bit           rdy_want;
  bit           mon_en = 1'b0;
  int           edge_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model of one rising edge: pop first, then consume the previous pair.
  task automatic model_edge(input bit clr);
    bit           o_set, f_set;
    logic [W-1:0] w;
    o_set = 1'b0;
    f_set = 1'b0;
    if (ifc.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (pd_en) begin
      if (pd_sof) begin
        if (m_in_frame && m_bits.size() != 0) f_set = 1'b1;
        m_bits.delete();
        m_in_frame = 1'b1;
      end
      if (m_in_frame) begin
        m_bits.push_back(pd_b0);
        m_bits.push_back(pd_b1);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = m_bits[i];
          m_bits.delete();
          if (exp_q.size() < D) exp_q.push_back(w);
          else                  o_set = 1'b1;
        end
      end
    end
    exp_ovf = o_set ? 1'b1 : (clr ? 1'b0 : exp_ovf);
    exp_frm = f_set ? 1'b1 : (clr ? 1'b0 : exp_frm);
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left just after a falling edge.
  task automatic pair(input bit b0, input bit b1, input bit en, input bit s, input bit clr);
    din     = b0;
    din_en  = en;
    sof     = s;
    clr_err = clr;
    @(posedge clk);
    edge_cnt++;
    model_edge(clr);
    pd_en  = en;
    pd_sof = s;
    pd_b0  = b0;
    pd_b1  = b1;
    #1;
    din           = b1;
    clr_err       = 1'b0;
    ifc.out_ready = rdy_want;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pair(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit with_sof, input int gap_at, input int gaps);
    for (int p = 0; p < NP; p++) begin
      if (p == gap_at) idle(gaps);
      pair(w[2*p], w[2*p+1], 1'b1, with_sof && (p == 0), 1'b0);
    end
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    din     = 1'b0;
    din_en  = 1'b0;
    sof     = 1'b0;
    clr_err = 1'b0;
    #1;
    chk("rst_valid", 32'(ifc.out_valid), 32'(0));
    chk("rst_data",  32'(ifc.out_data),  32'(0));
    chk("rst_ovf",   32'(ovf),           32'(0));
    chk("rst_frm",   32'(frm_err),       32'(0));
    chk("rst_state", 32'(dbg_state),     32'(IDLE));
    exp_q.delete();
    m_bits.delete();
    m_in_frame = 1'b0;
    exp_ovf    = 1'b0;
    exp_frm    = 1'b0;
    pd_en      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(ifc.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_data", 32'(ifc.out_data), 32'(exp_q[0]));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      chk("frm_err", 32'(frm_err), 32'(exp_frm));
      if (ifc.out_valid) valid_edges.push_back(edge_cnt);
      if (ifc.out_valid && ifc.out_ready) got_q.push_back(ifc.out_data);
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] word;
    int           gap_at;
    int           gaps;
    int           exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic clear_logs();
    valid_edges.delete();
    got_q.delete();
  endtask

  initial begin
    int e0;
    rst_n         = 1'b1;
    din           = 1'b0;
    din_en        = 1'b0;
    sof           = 1'b0;
    clr_err       = 1'b0;
    rdy_want      = 1'b1;
    ifc.out_ready = 1'b1;
    #2;
    do_reset();

    tbl[0] = '{word: 8'hA5, gap_at: NP, gaps: 0, exp_lat: 4};
    tbl[1] = '{word: 8'h3C, gap_at: NP, gaps: 0, exp_lat: 4};
    tbl[2] = '{word: 8'hA5, gap_at: 2,  gaps: 2, exp_lat: 6};
    tbl[3] = '{word: 8'h00, gap_at: 1,  gaps: 1, exp_lat: 5};
    tbl[4] = '{word: 8'hFF, gap_at: NP, gaps: 0, exp_lat: 4};
    tbl[5] = '{word: 8'h81, gap_at: 3,  gaps: 3, exp_lat: 7};

    // Single words: latency, one valid cycle, data.
    for (int v = 0; v < 6; v++) begin
      idle(3);
      clear_logs();
      e0 = edge_cnt + 1;
      send_word(tbl[v].word, 1'b1, tbl[v].gap_at, tbl[v].gaps);
      idle(8);
      chk("vec_nvalid", 32'(valid_edges.size()), 32'(1));
      if (valid_edges.size() > 0) chk("vec_lat", 32'(valid_edges[0] - e0), 32'(tbl[v].exp_lat));
      chk("vec_ngot", 32'(got_q.size()), 32'(1));
      if (got_q.size() > 0) chk("vec_word", 32'(got_q[0]), 32'(tbl[v].word));
    end

    // Back-to-back words without a second sof.
    clear_logs();
    e0 = edge_cnt + 1;
    send_word(8'h3C, 1'b1, NP, 0);
    send_word(8'hFF, 1'b0, NP, 0);
    idle(8);
    chk("b2b_nvalid", 32'(valid_edges.size()), 32'(2));
    if (valid_edges.size() == 2) begin
      chk("b2b_lat0", 32'(valid_edges[0] - e0), 32'(4));
      chk("b2b_lat1", 32'(valid_edges[1] - e0), 32'(8));
    end
    if (got_q.size() == 2) begin
      chk("b2b_w0", 32'(got_q[0]), 32'(8'h3C));
      chk("b2b_w1", 32'(got_q[1]), 32'(8'hFF));
    end else chk("b2b_ngot", 32'(got_q.size()), 32'(2));

    // Framing error: restart mid-word, then clear.
    clear_logs();
    pair(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    pair(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(8'h96, 1'b1, NP, 0);
    idle(6);
    chk("frm_set", 32'(frm_err), 32'(1));
    chk("frm_ngot", 32'(got_q.size()), 32'(1));
    if (got_q.size() > 0) chk("frm_word", 32'(got_q[0]), 32'(8'h96));
    pair(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("frm_clr", 32'(frm_err), 32'(0));

    // Overflow: three words into a two-entry FIFO with no consumer.
    rdy_want = 1'b0;
    idle(2);
    clear_logs();
    send_word(8'h11, 1'b1, NP, 0);
    send_word(8'h22, 1'b0, NP, 0);
    send_word(8'h33, 1'b0, NP, 0);
    chk("ovf_before", 32'(ovf), 32'(0));
    idle(1);
    chk("ovf_set", 32'(ovf), 32'(1));
    chk("ovf_head", 32'(ifc.out_data), 32'(8'h11));
    rdy_want = 1'b1;
    idle(6);
    chk("ovf_ngot", 32'(got_q.size()), 32'(2));
    if (got_q.size() == 2) begin
      chk("ovf_w0", 32'(got_q[0]), 32'(8'h11));
      chk("ovf_w1", 32'(got_q[1]), 32'(8'h22));
    end
    pair(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf), 32'(0));

    // Full FIFO with push and pop on the same edge: no overflow.
    rdy_want = 1'b0;
    idle(2);
    clear_logs();
    send_word(8'h44, 1'b1, NP, 0);
    send_word(8'h55, 1'b0, NP, 0);
    for (int p = 0; p < NP; p++) begin
      if (p == NP - 1) rdy_want = 1'b1;
      pair(p == 0 ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle(1);
    chk("pp_ovf", 32'(ovf), 32'(0));
    idle(6);
    chk("pp_ngot", 32'(got_q.size()), 32'(3));
    if (got_q.size() == 3) begin
      chk("pp_w0", 32'(got_q[0]), 32'(8'h44));
      chk("pp_w1", 32'(got_q[1]), 32'(8'h55));
      chk("pp_w2", 32'(got_q[2]), 32'(8'hFE));
    end

    // Reset mid-word with a word still queued.
    rdy_want = 1'b0;
    idle(1);
    send_word(8'h77, 1'b1, NP, 0);
    pair(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pair(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    rdy_want = 1'b1;
    clear_logs();
    send_word(8'hC3, 1'b0, NP, 0);
    idle(6);
    chk("rst_noword", 32'(got_q.size()), 32'(0));
    send_word(8'h5A, 1'b1, NP, 0);
    idle(6);
    chk("rst_ngot", 32'(got_q.size()), 32'(1));
    if (got_q.size() > 0) chk("rst_word", 32'(got_q[0]), 32'(8'h5A));

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rdy_want = ($urandom_range(0, 3) != 0);
      pair(1'($urandom), 1'($urandom), $urandom_range(0, 9) < 8,
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end
    rdy_want = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
